// File: rtl/fifo_rd_framer_pkg.sv
// Shared types and constants for the FIFO read-side packet framer.
package fifo_rd_framer_pkg;

    // Framer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output buffer depth; two entries let the FIFO keep streaming at one
    // word per cycle while fifo_rd looks only at registered occupancy.
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO-ordered buffer between the FIFO read port and the stream.
// Occupancy is registered so the writer can decide to push without seeing
// the reader's ready.
module stream_skid2
    import fifo_rd_framer_pkg::*;
#(
    parameter int PW = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [PW-1:0]    rd_data,
    output logic [OCC_W-1:0] occ
);

    logic [PW-1:0] mem [BUF_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          push;
    logic          pop;

    assign rd_valid = (occ != '0);
    assign rd_data  = mem[rd_ptr];
    assign pop      = rd_valid & rd_ready;
    // A full buffer never accepts a write; the framer does not issue one.
    assign push     = wr_en & (occ != OCC_W'(BUF_DEPTH));

    // Storage, pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_rd_framer.sv
// Pops words from a show-ahead FIFO and frames them into fixed-length
// valid/ready packets with last on the final beat. Consumer backpressure is
// absorbed by a 2-entry buffer so it never reaches fifo_rd combinationally.
module fifo_rd_framer
    import fifo_rd_framer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             len_err,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_data,
    output logic             fifo_rd,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    input  logic             m_ready
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_cnt;
    logic [OCC_W-1:0] occ;
    logic             wr_last;
    logic             last_acc;
    logic             buf_valid;
    logic [DW:0]      head;

    // Read only when the buffer has room by its registered count; the
    // consumer's ready is deliberately absent from this term.
    assign fifo_rd  = (state == RUN) & ~fifo_empty &
                      (occ < OCC_W'(BUF_DEPTH)) & (rd_cnt != len_q);
    assign wr_last  = (rd_cnt == len_q - LEN_W'(1));
    assign last_acc = m_valid & m_ready & m_last;
    assign busy     = (state != IDLE);

    stream_skid2 #(
        .PW (DW + 1)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .wr_en    (fifo_rd),
        .wr_data  ({wr_last, fifo_data}),
        .rd_valid (buf_valid),
        .rd_ready (m_ready),
        .rd_data  (head),
        .occ      (occ)
    );

    assign m_valid = buf_valid;
    assign m_data  = head[DW-1:0];
    assign m_last  = buf_valid & head[DW];

    // Packet FSM with length/read counters and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            rd_cnt  <= '0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            if (abort) begin
                // Abort wins over everything, including a same-cycle start.
                state  <= IDLE;
                rd_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (pkt_len == '0) begin
                                len_err <= 1'b1;
                            end else begin
                                len_q  <= pkt_len;
                                rd_cnt <= '0;
                                state  <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (fifo_rd) begin
                            rd_cnt <= rd_cnt + LEN_W'(1);
                            if (wr_last) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (last_acc) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Directed bench for fifo_rd_framer with a behavioural show-ahead FIFO.
module tb_fifo_rd_framer;

    localparam int DW    = 32;
    localparam int LEN_W = 16;
    localparam int LOGN  = 256;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] pkt_len;
    logic             abort;
    logic             busy;
    logic             done;
    logic             len_err;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_data;
    logic             fifo_rd;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic             m_ready;

    fifo_rd_framer #(
        .DW    (DW),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pkt_len    (pkt_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    logic          hold_empty;
    int            cyc, base, rd_viol;
    logic          lg_rd[LOGN], lg_vld[LOGN], lg_busy[LOGN], lg_done[LOGN], lg_lerr[LOGN];
    logic [DW-1:0] bt_data[$];
    logic          bt_last[$];
    int            bt_idx[$];
    logic          prev_stall, prev_last;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic fifo_drive();
        fifo_empty = hold_empty || (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) q.push_back(w + DW'(i));
        fifo_drive();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < LOGN; i++) begin
            lg_rd[i] = 0; lg_vld[i] = 0; lg_busy[i] = 0; lg_done[i] = 0; lg_lerr[i] = 0;
        end
        bt_data.delete(); bt_last.delete(); bt_idx.delete();
        prev_stall = 0;
    endtask

    // One clock: sample at negedge, apply the FIFO pop just after posedge.
    task automatic tick();
        int   idx;
        logic popping;
        @(negedge clk);
        idx = cyc - base;
        if (idx >= 0 && idx < LOGN) begin
            lg_rd[idx] = fifo_rd; lg_vld[idx] = m_valid; lg_busy[idx] = busy;
            lg_done[idx] = done; lg_lerr[idx] = len_err;
        end
        if (fifo_rd && fifo_empty) rd_viol++;
        if (prev_stall && m_valid) begin
            chk("hold_data", m_data, prev_data);
            chk("hold_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
            bt_data.push_back(m_data); bt_last.push_back(m_last); bt_idx.push_back(idx);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        popping    = fifo_rd;
        @(posedge clk);
        #1;
        if (popping && q.size() != 0) q.delete(0);
        cyc++;
        fifo_drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_pkt(input int len);
        clear_logs();
        pkt_len = LEN_W'(len);
        start   = 1'b1;
        base    = cyc;
        tick();
        start   = 1'b0;
    endtask

    // Pack log bits [0..n-1] of a chosen log into a vector (bit i = index i).
    function automatic logic [31:0] bits_of(input int sel, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n && i < 32; i++) begin
            case (sel)
                0: v[i] = lg_rd[i];
                1: v[i] = lg_vld[i];
                2: v[i] = lg_busy[i];
                3: v[i] = lg_done[i];
                default: v[i] = lg_lerr[i];
            endcase
        end
        return v;
    endfunction

    function automatic int n_done();
        int c;
        c = 0;
        for (int i = 0; i < LOGN; i++) c += int'(lg_done[i]);
        return c;
    endfunction

    // Beats must be first, first+1, ...; last only on the final one.
    task automatic chk_beats(input string tag, input int n, input logic [DW-1:0] first, input int first_idx);
        chk({tag, "_nbeats"}, bt_data.size(), n);
        for (int k = 0; k < n && k < bt_data.size(); k++) begin
            chk({tag, "_data"}, bt_data[k], first + DW'(k));
            chk({tag, "_last"}, bt_last[k], (k == n - 1));
            if (first_idx >= 0) chk({tag, "_beat_cyc"}, bt_idx[k], first_idx + k);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pkt_len = '0; abort = 1'b0; m_ready = 1'b1;
        hold_empty = 1'b0; cyc = 0; base = 0; rd_viol = 0;
        clear_logs();
        push(32'h10, 4);
        #23;
        // Reset state
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_len_err", len_err, 0); chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_m_valid", m_valid, 0); chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic 4-word packet, back-to-back
        start_pkt(4);
        run(8);
        chk("basic_rd", bits_of(0, 9), 32'h1E);
        chk("basic_done", bits_of(3, 9), 32'h40);
        chk("basic_busy", bits_of(2, 9), 32'h3E);
        chk_beats("basic", 4, 32'h10, 2);

        // Backpressure: ready low for indices 3..7
        push(32'h20, 6);
        start_pkt(6);
        for (int i = 1; i < 16; i++) begin
            m_ready = !(i >= 3 && i <= 7);
            tick();
        end
        m_ready = 1'b1;
        chk("bp_rd_head", bits_of(0, 4), 32'hE);
        chk("bp_rd_stall", (bits_of(0, 8) >> 4) & 32'hF, 0);
        chk("bp_done_at13", lg_done[13], 1);
        chk("bp_ndone", n_done(), 1);
        chk_beats("bp", 6, 32'h20, -1);

        // FIFO empty for indices 3..5 mid-packet
        push(32'h30, 5);
        start_pkt(5);
        for (int i = 1; i < 13; i++) begin
            hold_empty = (i >= 3 && i <= 5);
            fifo_drive();
            tick();
        end
        hold_empty = 1'b0; fifo_drive();
        chk("uf_rd", bits_of(0, 13), 32'h1C6);
        chk("uf_vld_gap", {lg_vld[4], lg_vld[5]}, 2'b00);
        chk("uf_done", bits_of(3, 13), 32'h400);
        chk_beats("uf", 5, 32'h30, -1);

        // Single-word packet
        push(32'h60, 2);
        start_pkt(1);
        run(6);
        chk("one_rd", bits_of(0, 7), 32'h02);
        chk("one_done", bits_of(3, 7), 32'h08);
        chk_beats("one", 1, 32'h60, 2);
        q.delete(); fifo_drive();

        // Zero length
        push(32'h66, 1);
        start_pkt(0);
        run(4);
        chk("zero_lerr", bits_of(4, 5), 32'h02);
        chk("zero_busy", bits_of(2, 5), 0);
        chk("zero_rd", bits_of(0, 5), 0);
        q.delete(); fifo_drive();

        // Abort with two words buffered
        push(32'h40, 8);
        m_ready = 1'b0;
        start_pkt(8);
        run(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(5);
        chk("ab_before", {lg_vld[3], lg_busy[3], lg_rd[3]}, 3'b110);
        chk("ab_after", {lg_vld[4], lg_busy[4]}, 2'b00);
        chk("ab_rd", bits_of(0, 9), 32'h06);
        chk("ab_ndone", n_done(), 0);
        m_ready = 1'b1;
        q.delete(); fifo_drive();

        // Reset mid-packet, then a normal 3-word packet
        push(32'h50, 4);
        start_pkt(4);
        run(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, done, len_err, fifo_rd, m_valid, m_last}, 6'b0);
        chk("mid_rst_data", m_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        push(32'h58, 3);
        start_pkt(3);
        run(6);
        chk("rs_rd", bits_of(0, 7), 32'h0E);
        chk("rs_done", bits_of(3, 7), 32'h20);
        chk_beats("rs", 3, 32'h58, 2);

        // Start while busy is ignored
        push(32'h70, 5);
        start_pkt(3);
        tick();
        start = 1'b1; pkt_len = 16'd2;
        tick();
        start = 1'b0;
        run(10);
        chk("sb_rd", bits_of(0, 13), 32'h0E);
        chk("sb_ndone", n_done(), 1);
        chk("sb_lerr", bits_of(4, 13), 0);
        chk("sb_left", q.size(), 2);
        chk_beats("sb", 3, 32'h70, 2);

        chk("rd_when_empty", rd_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_framer.md
Name: fifo_rd_framer

Overview:
- Downstream consumer of the width-converting async FIFO. It runs entirely in the FIFO read-clock domain.
- Pops DW-bit words through the FIFO read port. Protocol on that port: show-ahead data, valid whenever empty is low, consumed by a read request.
- Emits the words as a valid/ready stream, framed into packets of a programmable word count, with last on the final beat.
- A 2-entry output buffer isolates m_ready from fifo_rd, so the consumer's backpressure never combinationally reaches the FIFO.

Parameters:
- DW, 32, data word width; must equal the FIFO read width.
- LEN_W, 16, width of the packet-length and word counters; maximum packet is 2^LEN_W-1 words.

Ports:
- clk  input  1  clock; same clock as the FIFO read side.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins one packet of pkt_len words.
- pkt_len  input  LEN_W  words per packet; sampled on start.
- abort  input  1  pulse; abandons the current packet.
- busy  output  1  high while a packet is in progress.
- done  output  1  single-cycle pulse after the last beat is accepted.
- len_err  output  1  single-cycle pulse when start arrives with pkt_len==0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DW  FIFO show-ahead read data.
- fifo_rd  output  1  FIFO read request.
- m_valid  output  1  stream valid.
- m_data  output  DW  stream data.
- m_last  output  1  final beat of the packet.
- m_ready  input  1  stream ready.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all counters 0; buffer occupancy 0.
  - Outputs: busy=0, done=0, len_err=0, fifo_rd=0, m_valid=0, m_last=0, m_data=0.
  - Reset mid-packet discards all buffered words. Words already popped from the FIFO are lost.
- State machine states: IDLE, RUN, DRAIN.
- IDLE:
  - start with pkt_len!=0: latch len_q=pkt_len, rd_cnt=0, go to RUN.
  - start with pkt_len==0: pulse len_err next cycle and stay in IDLE.
- RUN:
  - fifo_rd = ~fifo_empty & (occ<2) & (rd_cnt!=len_q).
  - occ is the registered buffer occupancy. fifo_rd never depends on m_ready.
  - fifo_rd is never asserted while fifo_empty=1.
  - On fifo_rd: fifo_data is written into the buffer together with last=(rd_cnt==len_q-1), and rd_cnt increments.
  - When the read of word len_q-1 fires, go to DRAIN.
- DRAIN:
  - fifo_rd=0.
  - When the beat with last=1 is accepted (m_valid & m_ready & m_last): go to IDLE and pulse done in the following cycle.
- busy=1 in RUN and DRAIN.
- start while busy is ignored; no error is flagged.
- Buffer:
  - 2 entries, FIFO order.
  - m_valid = (occ!=0); m_data/m_last come from the head entry.
  - Next occupancy: occ_next = occ + fifo_rd - (m_valid & m_ready).
  - Latency: a word read in cycle N is first presented on m_data in cycle N+1.
  - Throughput: 1 word/cycle sustained while the FIFO is non-empty and m_ready=1.
- Stream rule: once m_valid=1, m_data and m_last hold stable until accepted.
- abort, in any state:
  - Next cycle: state=IDLE, occ=0, m_valid=0, busy=0; no done pulse.
  - abort takes priority over start in the same cycle.
- Simultaneous fifo_rd and beat accept with occ=1: occ stays 1. There is no bubble.
- Single-word packet (len_q=1): the first read carries last=1 and goes straight to DRAIN.
- Counter width: rd_cnt is LEN_W bits, compared against len_q, and never wraps within a packet.

Decomposition:
- Shared package fifo_rd_framer_pkg:
  - state enum (IDLE/RUN/DRAIN);
  - buffer depth constant BUF_DEPTH=2.
- Sub-module stream_skid2:
  - 2-entry buffer with {data,last} payload;
  - ports wr_en/wr_data, rd valid/ready, registered occ.
- The top level holds the FSM, counters and fifo_rd logic.

Test Plan:
- Basic packet: FIFO preloaded with 0x10..0x13, start with pkt_len=4, m_ready=1 -> four fifo_rd cycles back-to-back; m_data 0x10,0x11,0x12,0x13 on consecutive cycles starting 1 cycle after the first read; m_last only on 0x13; done 1 cycle after that beat; busy drops.
- Backpressure: pkt_len=6, m_ready low for 5 cycles mid-packet -> fifo_rd stops once occ=2; no word lost or duplicated; m_data stable while stalled; full sequence delivered in order.
- FIFO underflow: FIFO empty for 3 cycles mid-packet -> fifo_rd=0 while empty; m_valid drops when the buffer drains; the packet resumes and completes with correct last.
- Boundaries: pkt_len=1 -> exactly one fifo_rd; the beat carries m_last=1; done pulses. start with pkt_len=0 -> len_err pulse; busy stays 0; no fifo_rd.
- Abort/reset: abort after 2 of 8 words (occ=2) -> next cycle m_valid=0 and busy=0; no done. rst_n asserted mid-packet -> all outputs 0 immediately. A subsequent start with pkt_len=3 works normally.
- Start while busy: a second start during RUN -> ignored; exactly one packet framed; exactly one done.
